// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding and requester identifiers.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ_IF = 1'b0;
   localparam req_id_t REQ_D  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and data requesters. Data is preferred,
// except that a waiting fetch wins once the data streak reaches its limit.
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_DSTREAK = 4
) (
   input  logic       if_req,
   input  logic       d_req,
   input  logic [3:0] streak,
   output req_id_t    grant
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

   // Choose the requester that owns the next memory transaction.
   always_comb begin
      grant = REQ_D;
      if (if_req && !d_req) begin
         grant = REQ_IF;
      end else if (if_req && (streak == STREAK_MAX)) begin
         grant = REQ_IF;
      end else begin
         grant = REQ_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified memory between an instruction-fetch port and a
// data port. One transaction at a time: grant in IDLE, MEM_LAT cycles in BUSY,
// one RESP cycle carrying the done pulse.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT     = 2,
   parameter int MAX_DSTREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t      state_r,  state_s;
   logic [3:0]  cnt_r,    cnt_s;
   logic [3:0]  streak_r, streak_s;
   req_id_t     gid_r,    gid_s;
   logic [31:0] addr_r,   addr_s;
   logic [31:0] wdata_r,  wdata_s;
   logic        we_r,     we_s;
   logic [31:0] d_rdata_r;
   logic [31:0] mem_addr_s, mem_wdata_s;
   logic        mem_read_s, mem_write_s;
   logic        last_busy_s;
   req_id_t     pick_s;

   mem_arb_pick #(.MAX_DSTREAK(MAX_DSTREAK)) u_pick (
      .if_req (if_req),
      .d_req  (d_req),
      .streak (streak_r),
      .grant  (pick_s)
   );

   assign last_busy_s = (state_r == BUSY) && (cnt_r == 4'd0);

   // A store leaves the load-data register untouched but reports zero data.
   assign d_rdata = we_r ? 32'd0 : d_rdata_r;

   // Next-state, grant latching and next-cycle memory strobes.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      streak_s    = streak_r;
      gid_s       = gid_r;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      we_s        = we_r;
      mem_addr_s  = 32'd0;
      mem_wdata_s = 32'd0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (if_req || d_req) begin
               state_s = BUSY;
               cnt_s   = LAT_M1;
               gid_s   = pick_s;
               if (pick_s == REQ_D) begin
                  addr_s   = d_addr;
                  wdata_s  = d_wdata;
                  we_s     = d_we;
                  streak_s = if_req ? (streak_r + 4'd1) : streak_r;
               end else begin
                  addr_s   = if_addr;
                  wdata_s  = 32'd0;
                  we_s     = 1'b0;
                  streak_s = 4'd0;
               end
               mem_addr_s  = addr_s;
               mem_wdata_s = wdata_s;
               mem_read_s  = !we_s;
               // With a one-cycle latency the first BUSY cycle is also the last.
               mem_write_s = we_s && (cnt_s == 4'd0);
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r != 4'd0) begin
               cnt_s       = cnt_r - 4'd1;
               mem_addr_s  = addr_r;
               mem_wdata_s = wdata_r;
               mem_read_s  = !we_r;
               mem_write_s = we_r && (cnt_s == 4'd0);
            end else begin
               state_s = RESP;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, latched transaction, registered memory strobes, done and read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= 4'd0;
         streak_r  <= 4'd0;
         gid_r     <= REQ_IF;
         addr_r    <= 32'd0;
         wdata_r   <= 32'd0;
         we_r      <= 1'b0;
         d_rdata_r <= 32'd0;
         if_rdata  <= 32'd0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         streak_r  <= streak_s;
         gid_r     <= gid_s;
         addr_r    <= addr_s;
         wdata_r   <= wdata_s;
         we_r      <= we_s;
         mem_addr  <= mem_addr_s;
         mem_wdata <= mem_wdata_s;
         mem_read  <= mem_read_s;
         mem_write <= mem_write_s;
         if_done   <= last_busy_s && (gid_r == REQ_IF);
         d_done    <= last_busy_s && (gid_r == REQ_D);
         if (last_busy_s && (gid_r == REQ_IF)) begin
            if_rdata <= mem_rdata;
         end else begin
            if_rdata <= if_rdata;
         end
         if (last_busy_s && (gid_r == REQ_D) && !we_r) begin
            d_rdata_r <= mem_rdata;
         end else begin
            d_rdata_r <= d_rdata_r;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a main instance at MEM_LAT=2
// with a small word memory, plus MEM_LAT=1 and MEM_LAT=15 instances.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_done, d_done, mem_read, mem_write;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:63];

   logic        sw_if_req    [2];
   logic        sw_d_req     [2];
   logic        sw_if_done   [2];
   logic        sw_d_done    [2];
   logic        sw_mem_read  [2];
   logic        sw_mem_write [2];
   logic [31:0] sw_if_rdata  [2];
   logic [31:0] sw_d_rdata   [2];
   logic [31:0] sw_mem_addr  [2];
   logic [31:0] sw_mem_wdata [2];
   logic [31:0] sw_mem_rdata [2];

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;

   mem_arbiter #(.MEM_LAT(2), .MAX_DSTREAK(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.MEM_LAT(1), .MAX_DSTREAK(4)) dut_l1 (
      .clk(clk), .rst(rst),
      .if_req(sw_if_req[0]), .if_addr(32'h0000_0044), .if_done(sw_if_done[0]),
      .if_rdata(sw_if_rdata[0]),
      .d_req(sw_d_req[0]), .d_we(1'b1), .d_addr(32'h0000_0048), .d_wdata(32'hA5A5_0001),
      .d_done(sw_d_done[0]), .d_rdata(sw_d_rdata[0]),
      .mem_addr(sw_mem_addr[0]), .mem_wdata(sw_mem_wdata[0]), .mem_read(sw_mem_read[0]),
      .mem_write(sw_mem_write[0]), .mem_rdata(sw_mem_rdata[0])
   );

   mem_arbiter #(.MEM_LAT(15), .MAX_DSTREAK(4)) dut_l15 (
      .clk(clk), .rst(rst),
      .if_req(sw_if_req[1]), .if_addr(32'h0000_0044), .if_done(sw_if_done[1]),
      .if_rdata(sw_if_rdata[1]),
      .d_req(sw_d_req[1]), .d_we(1'b1), .d_addr(32'h0000_0048), .d_wdata(32'hA5A5_0001),
      .d_done(sw_d_done[1]), .d_rdata(sw_d_rdata[1]),
      .mem_addr(sw_mem_addr[1]), .mem_wdata(sw_mem_wdata[1]), .mem_read(sw_mem_read[1]),
      .mem_write(sw_mem_write[1]), .mem_rdata(sw_mem_rdata[1])
   );

   // Latency-sweep memories return the inverted address.
   assign sw_mem_rdata[0] = ~sw_mem_addr[0];
   assign sw_mem_rdata[1] = ~sw_mem_addr[1];

   // Main memory read port is combinational.
   assign mem_rdata = mem[mem_addr[7:2]];

   // Clock generator.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Main memory: preset contents on reset, write on the store strobe.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
         mem[4] <= 32'hDEAD_BEEF;
      end else if (mem_write) begin
         mem[mem_addr[7:2]] <= mem_wdata;
      end
   end

   // Count write strobes and done pulses of the main instance.
   always @(negedge clk) begin
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (if_done || d_done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sweep(input int k, input int lat);
      int  cyc;
      int  reads;
      int  wrs;
      int  wr_at;
      bit  seen;
      cyc = 0; reads = 0; seen = 1'b0;
      sw_if_req[k] = 1'b1;
      while (!seen && cyc < 40) begin
         step();
         cyc++;
         if (sw_mem_read[k]) reads++;
         if (sw_if_done[k]) seen = 1'b1;
      end
      sw_if_req[k] = 1'b0;
      check("sweep_fetch_latency", cyc, lat + 1);
      check("sweep_fetch_reads", reads, lat);
      check("sweep_fetch_rdata", sw_if_rdata[k], 32'hFFFF_FFBB);
      step();
      cyc = 0; wrs = 0; wr_at = 0; seen = 1'b0;
      sw_d_req[k] = 1'b1;
      while (!seen && cyc < 40) begin
         step();
         cyc++;
         if (sw_mem_write[k]) begin
            wrs++;
            wr_at = cyc;
         end
         if (sw_d_done[k]) seen = 1'b1;
      end
      sw_d_req[k] = 1'b0;
      check("sweep_store_latency", cyc, lat + 1);
      check("sweep_store_writes", wrs, 1);
      check("sweep_store_write_cycle", wr_at, lat);
      check("sweep_store_rdata", sw_d_rdata[k], 32'd0);
      step();
   endtask

   initial begin
      int nd;
      int gap;
      int last_d;
      int cyc;
      int wr0;
      int dn0;
      bit seen;

      rst = 1'b1;
      if_req = 1'b0; if_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
      for (int k = 0; k < 2; k++) begin
         sw_if_req[k] = 1'b0;
         sw_d_req[k]  = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      check("rst_strobes", {if_done, d_done, mem_read, mem_write}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);

      // Fetch-only read of 0x10.
      if_req = 1'b1; if_addr = 32'h10;
      step();
      check("f_c1_read", mem_read, 32'd1);
      check("f_c1_addr", mem_addr, 32'h10);
      check("f_c1_done", if_done, 32'd0);
      step();
      check("f_c2_read", mem_read, 32'd1);
      check("f_c2_done", if_done, 32'd0);
      step();
      check("f_c3_done", if_done, 32'd1);
      check("f_c3_rdata", if_rdata, 32'hDEAD_BEEF);
      check("f_c3_read_off", mem_read, 32'd0);
      check("f_c3_addr_off", mem_addr, 32'd0);
      if_req = 1'b0;
      step();

      // Simultaneous fetch and store: data first, fetch granted at cycle 4.
      wr0 = wr_cnt;
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
      step();
      check("s_c1_addr", mem_addr, 32'h20);
      check("s_c1_write", mem_write, 32'd0);
      check("s_c1_read", mem_read, 32'd0);
      step();
      check("s_c2_write", mem_write, 32'd1);
      check("s_c2_wdata", mem_wdata, 32'h1234_5678);
      step();
      check("s_c3_d_done", d_done, 32'd1);
      check("s_c3_if_done", if_done, 32'd0);
      check("s_c3_d_rdata", d_rdata, 32'd0);
      d_req = 1'b0; d_we = 1'b0;
      step();
      check("s_c4_idle_read", mem_read, 32'd0);
      step();
      check("s_c5_fetch_read", mem_read, 32'd1);
      check("s_c5_fetch_addr", mem_addr, 32'h10);
      step();
      step();
      check("s_c7_if_done", if_done, 32'd1);
      if_req = 1'b0;
      check("s_write_count", wr_cnt - wr0, 32'd1);
      check("s_mem_word", mem[8], 32'h1234_5678);
      step();

      // Load of the stored word.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      step(); step(); step();
      check("l_done", d_done, 32'd1);
      check("l_rdata", d_rdata, 32'h1234_5678);
      check("l_if_rdata_kept", if_rdata, 32'hDEAD_BEEF);
      d_req = 1'b0;
      step();

      // Starvation guard: four data grants, then the fetch.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      if_req = 1'b1; if_addr = 32'h10;
      nd = 0; gap = 0; last_d = -1; cyc = 0; seen = 1'b0;
      while (!seen && cyc < 100) begin
         step();
         cyc++;
         if (d_done) begin
            if (last_d >= 0 && gap == 0) gap = cyc - last_d;
            last_d = cyc;
            nd++;
         end
         if (if_done) seen = 1'b1;
      end
      if_req = 1'b0; d_req = 1'b0;
      check("starve_fetch_seen", seen, 32'd1);
      check("starve_data_grants", nd, 32'd4);
      check("starve_throughput", gap, 32'd4);
      step();

      // Reset pulse in the first BUSY cycle of a store.
      wr0 = wr_cnt; dn0 = done_cnt;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFE_F00D;
      step();
      check("r_busy_read", mem_addr, 32'h30);
      rst = 1'b1;
      #2 rst = 1'b0;
      d_req = 1'b0; d_we = 1'b0;
      #1;
      check("r_strobes", {if_done, d_done, mem_read, mem_write}, 32'd0);
      repeat (5) step();
      check("r_no_write", wr_cnt - wr0, 32'd0);
      check("r_no_done", done_cnt - dn0, 32'd0);
      check("r_state_idle", 32'(dut.state_r), 32'd0);
      check("r_mem_addr", mem_addr, 32'd0);
      check("r_mem_wdata", mem_wdata, 32'd0);
      check("r_if_rdata", if_rdata, 32'd0);
      check("r_d_rdata", d_rdata, 32'd0);
      check("r_mem_word", mem[12], 32'd0);

      // Latency sweep.
      sweep(0, 1);
      sweep(1, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory access latency in cycles; legal range 1..15.
REQ-002 Parameter MAX_DSTREAK, default 4: consecutive data grants allowed while a fetch waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request, read-only; held until if_done.
REQ-006 if_addr  input  32  fetch byte address; stable while if_req is high.
REQ-007 if_done  output  1  one-cycle pulse; if_rdata is valid in the same cycle.
REQ-008 if_rdata  output  32  fetched word.
REQ-009 d_req  input  1  data request; held until d_done.
REQ-010 d_we  input  1  1 = store, 0 = load; stable while d_req is high.
REQ-011 d_addr, d_wdata  input  32 each  data address and store data; stable while d_req is high.
REQ-012 d_done  output  1  one-cycle pulse; d_rdata is valid for loads in the same cycle.
REQ-013 d_rdata  output  32  loaded word; 0 for stores.
REQ-014 mem_addr, mem_wdata  output  32 each  address and write data to the shared unified memory.
REQ-015 mem_read, mem_write  output  1 each  memory read and write strobes.
REQ-016 mem_rdata  input  32  combinational read data from memory.

Function
REQ-017 The FSM SHALL have three states:
- IDLE
- BUSY: lasts MEM_LAT cycles, counted by a 4-bit down-counter.
- RESP: lasts 1 cycle.
REQ-018 In IDLE, if any request is high, the FSM SHALL grant one request, latch its address, data and we into internal registers, and move to BUSY with the counter loaded to MEM_LAT-1.
REQ-019 Arbitration SHALL be as follows:
- Data wins by default.
- Fetch wins when if_req is high and the streak counter equals MAX_DSTREAK.
- A lone request always wins.
REQ-020 The streak counter SHALL increment on each data grant made while if_req is high, and clear on each fetch grant.
REQ-021 In BUSY, mem_addr SHALL equal the latched address and mem_read SHALL be 1 for loads and fetches.
REQ-022 mem_write SHALL be 1 only in the final BUSY cycle (counter = 0) of a store, so exactly one write occurs per store.
REQ-023 In the final BUSY cycle, mem_rdata SHALL be captured into the output data register, and the FSM SHALL move to RESP.
REQ-024 In RESP, exactly one of if_done or d_done SHALL be high, matching the granted requester, and the FSM SHALL return to IDLE.
REQ-025 Transaction latency from the grant cycle to done SHALL be MEM_LAT+1 cycles.
REQ-026 Back-to-back throughput SHALL be one transaction per MEM_LAT+2 cycles.
REQ-027 A requester that keeps req high in the cycle after its done SHALL be treated as issuing a new request.
REQ-028 Outside BUSY, mem_read, mem_write, mem_addr and mem_wdata SHALL all be 0.
REQ-029 A request that drops before its grant SHALL be ignored.
REQ-030 Request inputs SHALL be ignored while the FSM is in BUSY or RESP.
REQ-031 The data rdata register SHALL update only on loads; the fetch rdata register SHALL update only on fetches.
REQ-032 Address arithmetic SHALL be pass-through; memory wrap-around is the memory's responsibility.

Reset
REQ-033 rst SHALL force the following, including mid-transaction:
- state = IDLE
- counters = 0
- all outputs = 0
- latched registers = 0
REQ-034 A store aborted by reset before its final BUSY cycle SHALL produce no mem_write.
REQ-035 No done pulse SHALL be issued for an aborted transaction.

Structure
REQ-036 The shared package SHALL hold the state encoding (IDLE=0, BUSY=1, RESP=2) and the requester-ID constants (REQ_IF=0, REQ_D=1).
REQ-037 Arbitration and streak logic SHALL be one sub-module, mem_arb_pick, taking if_req, d_req and streak, and returning the grant ID.

Verification
REQ-038 Fetch-only read: memory word at 0x10 = 0xDEADBEEF; if_req held at if_addr=0x10 from cycle 0 -> if_done high at cycle 3 with if_rdata=0xDEADBEEF (MEM_LAT=2).
REQ-039 Simultaneous requests: if_req, and d_req as a store with d_addr=0x20 and d_wdata=0x12345678, both in cycle 0 -> data served first with one mem_write at cycle 2; fetch granted at cycle 4.
REQ-040 Starvation guard: d_req held continuously with if_req high -> fetch granted after exactly 4 data grants.
REQ-041 Reset mid-operation: rst pulses in the first BUSY cycle of a store -> no mem_write, no done, FSM in IDLE, all outputs 0.
REQ-042 Latency sweep: MEM_LAT=1 and MEM_LAT=15 -> done exactly MEM_LAT+1 cycles after grant, with mem_read high for MEM_LAT cycles.
